parity_arbiter: RTL and testbench
=================================

Name: parity_arbiter

Overview:
- Round-robin controller that shares one 8-bit data register and its XOR-reduction parity unit among NUM_REQ requesters.
- Grants one requester at a time and captures its data word into the shared register. Returns the word, its parity and the requester id through a valid/ready result port.
- Sits between several producer blocks and the single parity datapath, so no requester ever drives the register directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of each requester data word and of the shared register.
- CNT_W, 16, width of the saturating completed-transaction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high with stable data until its gnt bit pulses.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
- busy  output  1  high whenever state != IDLE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
- res_data  output  DATA_W  captured word (shared register contents).
- res_parity  output  1  XOR of all bits of res_data; 1 = odd number of ones.
- res_count  output  CNT_W  number of accepted results, saturating at all-ones.

Behaviour:
- Reset (synchronous, overrides everything, valid in any state):
  - state=IDLE; gnt=0, busy=0, res_valid=0, res_id=0, res_data=0, res_parity=0, res_count=0.
  - Round-robin pointer ptr=0; shared register=0.
  - Any in-flight transaction is dropped without a result.
- State IDLE:
  - If |req, winner = first index i with req[i]=1, scanning ptr, ptr+1, ... and wrapping modulo NUM_REQ.
  - Register winner into res_id and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT (exactly one cycle):
  - gnt[res_id]=1; all other gnt bits 0.
  - The shared register loads req_data[res_id] at the end of this cycle (register enable = 1 only in GRANT).
  - Go to REPORT.
  - If the requester drops req during GRANT, the capture still happens.
- State REPORT:
  - res_valid=1; res_data = register contents; res_parity = ^res_data (combinational from the register).
  - While res_ready=0: hold, with all result outputs stable.
  - When res_ready=1: the handshake completes that cycle. Next cycle state=IDLE, ptr=(res_id+1) mod NUM_REQ, res_count increments unless saturated.
- Latency and throughput:
  - Request seen in IDLE at cycle N: gnt at N+1, res_valid at N+2.
  - Best case one result every 3 cycles with res_ready tied high.
- Grant rules:
  - The granted requester must deassert req on the cycle after its gnt, otherwise it is re-arbitrated as a new request.
  - req changes during GRANT or REPORT are ignored until IDLE.
- Fairness: with all requests continuously asserted and NUM_REQ=4, grants follow 0,1,2,3,0,...
- res_id, res_data and res_parity keep their last values after leaving REPORT; they are meaningful only while res_valid=1.
- gnt never has more than one bit set; gnt and res_valid are never high in the same cycle.

Test Plan:
- Reset, then req=4'b0100 with data2=8'hA5 → gnt=4'b0100 one cycle later, next cycle res_valid=1, res_id=2, res_data=8'hA5, res_parity=0; res_count=1 after accept.
- Single req0 with data 8'h07, res_ready held low 5 cycles → res_valid, res_data=8'h07 and res_parity=1 stay stable for all 5 cycles, no new gnt; accept on the 6th cycle; IDLE next cycle.
- All four req held high, res_ready=1, requesters never drop req → gnt sequence 0001,0010,0100,1000,0001, spaced 3 cycles apart.
- ptr=2 (last winner 1) with req=4'b0011 → winner 0, because the scan wraps from 2 through 3 to 0.
- reset asserted during REPORT with res_valid=1 → next cycle res_valid=0, busy=0, res_count=0; following req0 is granted from IDLE with normal latency.
- CNT_W=2, eight back-to-back transactions → res_count reads 1,2,3,3,3,3,3,3.

Source files
------------

// File: rtl/parity_arbiter.sv
// parity_arbiter: round-robin sharing of one data register and its parity unit among NUM_REQ requesters.
module parity_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         busy,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic [DATA_W-1:0]            res_data,
    output logic                         res_parity,
    output logic [CNT_W-1:0]             res_count
);
    localparam int ID_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, GRANT, REPORT} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] ptr, win;
    logic found;
    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
                win = ID_W'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = found ? GRANT : IDLE;
            GRANT:   state_nxt = REPORT;
            REPORT:  state_nxt = res_ready ? IDLE : REPORT;
            default: state_nxt = IDLE;
        endcase
    end
    assign gnt        = (state == GRANT) ? NUM_REQ'(1) << res_id : '0;
    assign busy       = state != IDLE;
    assign res_valid  = state == REPORT;
    assign res_parity = ^res_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            res_id    <= '0;
            res_data  <= '0;
            res_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found)
                res_id <= win;
            if (state == GRANT)
                res_data <= req_data[res_id*DATA_W +: DATA_W];
            if (state == REPORT && res_ready) begin
                ptr <= (res_id == ID_W'(NUM_REQ - 1)) ? '0 : res_id + 1'b1;
                if (res_count != '1)
                    res_count <= res_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: directed checks of the parity arbiter, plus a 2-bit-counter instance for saturation.
module tb_parity_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        res_ready = 1'b0;
    logic [3:0]  gnt, gnt_s;
    logic        busy, busy_s, res_valid, res_valid_s, res_parity, res_parity_s;
    logic [1:0]  res_id, res_id_s;
    logic [7:0]  res_data, res_data_s;
    logic [15:0] res_count;
    logic [1:0]  res_count_s;
    int checks = 0;
    int errors = 0;

    parity_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
        .res_parity(res_parity), .res_count(res_count));

    parity_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt_s), .busy(busy_s),
        .res_valid(res_valid_s), .res_ready(res_ready), .res_id(res_id_s), .res_data(res_data_s),
        .res_parity(res_parity_s), .res_count(res_count_s));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Drive at the negedge, so a request set here is seen by the next posedge in IDLE.
    initial begin
        logic [7:0] words [4];
        logic [1:0] sat;
        words = '{8'h01, 8'h03, 8'h07, 8'hFF};
        repeat (2) cyc();
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_gnt", gnt, 0);
        check("rst_id", res_id, 0);
        check("rst_data", res_data, 0);
        check("rst_parity", res_parity, 0);
        check("rst_count", res_count, 0);
        reset = 1'b0;
        // Single requester 2 with A5.
        req = 4'b0100;
        req_data[23:16] = 8'hA5;
        cyc();
        check("t1_gnt", gnt, 4'b0100);
        check("t1_busy", busy, 1);
        check("t1_novalid", res_valid, 0);
        req = '0;
        cyc();
        check("t1_valid", res_valid, 1);
        check("t1_gnt_off", gnt, 0);
        check("t1_id", res_id, 2);
        check("t1_data", res_data, 8'hA5);
        check("t1_parity", res_parity, 0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("t1_count", res_count, 1);
        check("t1_idle", busy, 0);
        check("t1_valid_off", res_valid, 0);
        // Back-pressure: result holds while res_ready is low.
        req = 4'b0001;
        req_data[7:0] = 8'h07;
        cyc();
        check("t2_gnt", gnt, 4'b0001);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_hold_valid", res_valid, 1);
            check("t2_hold_data", res_data, 8'h07);
            check("t2_hold_parity", res_parity, 1);
            check("t2_hold_gnt", gnt, 0);
        end
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("t2_idle", busy, 0);
        check("t2_count", res_count, 2);
        // Winner 1 puts ptr at 2; then req 0011 wraps to 0.
        req = 4'b0010;
        req_data[15:8] = 8'h3C;
        cyc();
        check("t4_gnt1", gnt, 4'b0010);
        req = '0;
        res_ready = 1'b1;
        cyc();
        check("t4_id1", res_id, 1);
        check("t4_data1", res_data, 8'h3C);
        cyc();
        req = 4'b0011;
        cyc();
        check("t4_wrap_gnt", gnt, 4'b0001);
        req = '0;
        cyc();
        check("t4_wrap_id", res_id, 0);
        cyc();
        req = 4'b0011;
        cyc();
        check("t4_next_gnt", gnt, 4'b0010);
        req = '0;
        cyc();
        cyc();
        check("t4_count", res_count, 5);
        res_ready = 1'b0;
        // Reset during REPORT drops the transaction.
        req = 4'b0001;
        cyc();
        req = '0;
        cyc();
        check("t5_valid_pre", res_valid, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t5_valid", res_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_count", res_count, 0);
        check("t5_count_s", res_count_s, 0);
        req = 4'b0001;
        cyc();
        check("t5_gnt", gnt, 4'b0001);
        req = '0;
        cyc();
        check("t5_rvalid", res_valid, 1);
        check("t5_data", res_data, 8'h07);
        // Fairness and counter saturation with all requests held high.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req = 4'b1111;
        req_data = {words[3], words[2], words[1], words[0]};
        res_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            cyc();
            check("t3_gnt", gnt, 4'b0001 << (t % 4));
            check("t3_gnt_vld", res_valid, 0);
            cyc();
            check("t3_valid", res_valid, 1);
            check("t3_id", res_id, t % 4);
            check("t3_data", res_data, words[t % 4]);
            check("t3_parity", res_parity, (t % 2 == 0) ? 1 : 0);
            check("t3_rep_gnt", gnt, 0);
            cyc();
            sat = (t + 1 > 3) ? 2'd3 : 2'(t + 1);
            check("t3_count", res_count, t + 1);
            check("t3_count_s", res_count_s, sat);
            check("t3_idle_gnt", gnt, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
